// File: rtl/quarterwave_dds.sv
// rtl/quarterwave_dds.sv - phase accumulator and quadrant fold around an external quarter-wave sine table
// Optional cosine path: define QUARTERWAVE_DDS_COS_EN.
module quarterwave_dds #(
  parameter int ACC_WIDTH  = 32,
  parameter int QLUT_DEPTH = 8,
  parameter int DATA_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [ACC_WIDTH-1:0]    freq_word,
  input  logic [QLUT_DEPTH-1:0]   phase_offset,
  output logic [QLUT_DEPTH-3:0]   lut_addr,
  input  logic [DATA_WIDTH-1:0]   lut_value,
`ifdef QUARTERWAVE_DDS_COS_EN
  output logic [QLUT_DEPTH-3:0]   lut_addr_cos,
  input  logic [DATA_WIDTH-1:0]   lut_value_cos,
  output logic [DATA_WIDTH-1:0]   cos_out,
`endif
  output logic [DATA_WIDTH-1:0]   sine_out,
  output logic                    sine_valid
);

  localparam int AW = QLUT_DEPTH - 2;

  logic [ACC_WIDTH-1:0]  acc;
  logic [QLUT_DEPTH-1:0] p;
  logic [AW-1:0]         a;
  logic                  mirror;
  logic                  quad_q;
  logic                  valid1;

  // quad_q keeps only the sign half of the quadrant; the mirror half is folded into lut_addr
  assign p      = acc[ACC_WIDTH-1 -: QLUT_DEPTH] + phase_offset;
  assign mirror = p[QLUT_DEPTH-2];
  assign a      = p[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      lut_addr <= '0;
      quad_q   <= 1'b0;
      valid1   <= 1'b0;
    end else begin
      valid1 <= en;
      if (en) begin
        acc      <= acc + freq_word;
        lut_addr <= mirror ? ~a : a;
        quad_q   <= p[QLUT_DEPTH-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sine_out   <= '0;
      sine_valid <= 1'b0;
    end else begin
      sine_valid <= valid1;
      if (valid1) begin
        sine_out <= quad_q ? -lut_value : lut_value;
      end
    end
  end

`ifdef QUARTERWAVE_DDS_COS_EN
  logic [QLUT_DEPTH-1:0] pc;
  logic                  quad_c_q;

  // cosine leads sine by one quadrant
  assign pc = p + {2'b01, {AW{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_addr_cos <= '0;
      quad_c_q     <= 1'b0;
    end else if (en) begin
      lut_addr_cos <= pc[QLUT_DEPTH-2] ? ~pc[AW-1:0] : pc[AW-1:0];
      quad_c_q     <= pc[QLUT_DEPTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cos_out <= '0;
    end else if (valid1) begin
      cos_out <= quad_c_q ? -lut_value_cos : lut_value_cos;
    end
  end
`endif

endmodule

// File: tb/tb_quarterwave_dds.sv
// tb/tb_quarterwave_dds.sv - directed self-checking bench for quarterwave_dds with a behavioural sine table
module tb_quarterwave_dds;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] freq_word = '0;
  logic [7:0]  phase_offset = '0;
  logic [5:0]  lut_addr;
  logic [11:0] lut_value;
  logic [11:0] sine_out;
  logic        sine_valid;
  logic [11:0] tbl [64];
  logic [11:0] held_out;
  logic [5:0]  held_addr;
  int          n_cmp = 0;
  int          n_err = 0;

`ifdef QUARTERWAVE_DDS_COS_EN
  logic [5:0]  lut_addr_cos;
  logic [11:0] lut_value_cos;
  logic [11:0] cos_out;
  always_comb lut_value_cos = tbl[lut_addr_cos];
`endif

  always #5 clk = ~clk;
  always_comb lut_value = tbl[lut_addr];

  quarterwave_dds dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .freq_word    (freq_word),
    .phase_offset (phase_offset),
    .lut_addr     (lut_addr),
    .lut_value    (lut_value),
`ifdef QUARTERWAVE_DDS_COS_EN
    .lut_addr_cos (lut_addr_cos),
    .lut_value_cos(lut_value_cos),
    .cos_out      (cos_out),
`endif
    .sine_out     (sine_out),
    .sine_valid   (sine_valid)
  );

  // full-period sine at 256 points, half-sample offset, amplitude 0x7FE, rounded half away from zero
  function automatic logic [11:0] ref_sine(input int p);
    real x;
    int  r;
    x = 2046.0 * $sin(2.0 * PI * (real'(p % 256) + 0.5) / 256.0);
    if (x >= 0.0) r = $rtoi(x + 0.5);
    else          r = -$rtoi(-x + 0.5);
    return r[11:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) tbl[i] = ref_sine(i);

    @(negedge clk);
    check("reset_sine_out", {20'b0, sine_out}, 32'h0);
    check("reset_valid", {31'b0, sine_valid}, 32'h0);
    check("reset_lut_addr", {26'b0, lut_addr}, 32'h0);

    // scenario 1: full period at one table step per sample
    do_reset();
    freq_word = 32'h0100_0000; phase_offset = 8'd0; en = 1'b1;
    @(negedge clk);
    check("s1_valid_lat1", {31'b0, sine_valid}, 32'h0);
    for (int k = 0; k <= 256; k++) begin
      @(negedge clk);
      check("s1_valid", {31'b0, sine_valid}, 32'h1);
      check("s1_model", {20'b0, sine_out}, {20'b0, ref_sine(k)});
`ifdef QUARTERWAVE_DDS_COS_EN
      check("s1_cos", {20'b0, cos_out}, {20'b0, ref_sine(k + 64)});
`endif
      case (k)
        0, 127, 256: check("s1_hand_019", {20'b0, sine_out}, 32'h019);
        1:           check("s1_hand_04b", {20'b0, sine_out}, 32'h04B);
        2:           check("s1_hand_07d", {20'b0, sine_out}, 32'h07D);
        63, 64:      check("s1_hand_7fe", {20'b0, sine_out}, 32'h7FE);
        65:          check("s1_hand_7fd", {20'b0, sine_out}, 32'h7FD);
        128:         check("s1_hand_fe7", {20'b0, sine_out}, 32'hFE7);
        191:         check("s1_hand_802", {20'b0, sine_out}, 32'h802);
        default: ;
      endcase
    end

    // scenario 2: quarter-period offset
    do_reset();
    freq_word = 32'h0100_0000; phase_offset = 8'd64; en = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 64; k++) begin
      @(negedge clk);
      check("s2_model", {20'b0, sine_out}, {20'b0, ref_sine(k + 64)});
      if (k == 0)  check("s2_first_7fe", {20'b0, sine_out}, 32'h7FE);
      if (k == 64) check("s2_s64_fe7", {20'b0, sine_out}, 32'hFE7);
    end

    // scenario 3: -1 LSB increment wraps the accumulator backwards
    do_reset();
    freq_word = 32'hFFFF_FFFF; phase_offset = 8'd0; en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("s3_first_019", {20'b0, sine_out}, 32'h019);
    @(negedge clk);
    check("s3_second_fe7", {20'b0, sine_out}, 32'hFE7);
    @(negedge clk);
    check("s3_third_fe7", {20'b0, sine_out}, 32'hFE7);

    // scenario 4: en pattern 1,0,0,1 gives two pulses three cycles apart
    do_reset();
    freq_word = 32'h0100_0000; phase_offset = 8'd0; en = 1'b1;
    @(negedge clk); en = 1'b0;
    check("s4_valid_e0", {31'b0, sine_valid}, 32'h0);
    check("s4_addr_e0", {26'b0, lut_addr}, 32'h0);
    @(negedge clk);
    check("s4_valid_e1", {31'b0, sine_valid}, 32'h1);
    check("s4_out_e1", {20'b0, sine_out}, 32'h019);
    held_out = sine_out; held_addr = lut_addr;
    @(negedge clk); en = 1'b1;
    check("s4_valid_e2", {31'b0, sine_valid}, 32'h0);
    check("s4_hold_out_e2", {20'b0, sine_out}, {20'b0, held_out});
    check("s4_hold_addr_e2", {26'b0, lut_addr}, {26'b0, held_addr});
    @(negedge clk); en = 1'b0;
    check("s4_valid_e3", {31'b0, sine_valid}, 32'h0);
    check("s4_hold_out_e3", {20'b0, sine_out}, 32'h019);
    check("s4_addr_e3", {26'b0, lut_addr}, 32'h1);
    @(negedge clk);
    check("s4_valid_e4", {31'b0, sine_valid}, 32'h1);
    check("s4_out_e4", {20'b0, sine_out}, 32'h04B);
    @(negedge clk);
    check("s4_valid_e5", {31'b0, sine_valid}, 32'h0);
    check("s4_hold_out_e5", {20'b0, sine_out}, 32'h04B);

    // scenario 5: asynchronous reset mid-stream
    do_reset();
    freq_word = 32'h0100_0000; phase_offset = 8'd0; en = 1'b1;
    repeat (10) @(negedge clk);
    check("s5_pre_reset", {20'b0, sine_out}, {20'b0, ref_sine(8)});
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("s5_rst_out", {20'b0, sine_out}, 32'h0);
    check("s5_rst_valid", {31'b0, sine_valid}, 32'h0);
    check("s5_rst_addr", {26'b0, lut_addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("s5_post_valid0", {31'b0, sine_valid}, 32'h0);
    @(negedge clk);
    check("s5_post_valid1", {31'b0, sine_valid}, 32'h1);
    check("s5_post_first", {20'b0, sine_out}, 32'h019);

    // scenario 6: zero increment holds the phase
    do_reset();
    freq_word = 32'h0; phase_offset = 8'd0; en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("s6_valid", {31'b0, sine_valid}, 32'h1);
      check("s6_const", {20'b0, sine_out}, 32'h019);
    end
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("s6_valid_off", {31'b0, sine_valid}, 32'h0);
    check("s6_hold", {20'b0, sine_out}, 32'h019);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
